// File: rtl/cpu_loader.sv
// Byte-stream loader: fills CPU instruction/data memories, runs the CPU for a
// counted number of cycles, and dumps data memory back out over the tx stream.
module cpu_loader #(
  parameter int IMEM_WORDS = 128,
  parameter int DMEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        cpu_enable,
  output logic        busy,
  output logic        err
);

  typedef enum logic [3:0] {
    IDLE, CMD_LEN, LOAD_BYTES, LOAD_WR, RUN_LEN, RUN, DUMP_RD, DUMP_WAIT, DUMP_TX
  } state_t;

  localparam logic [1:0]  CMD_IMEM = 2'd0;
  localparam logic [1:0]  CMD_DMEM = 2'd1;
  localparam logic [1:0]  CMD_DUMP = 2'd2;
  localparam logic [16:0] IMEM_MAX = 17'(IMEM_WORDS);
  localparam logic [16:0] DMEM_MAX = 17'(DMEM_WORDS);

  state_t      state_q, state_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [63:0] word_q, word_d;
  logic        rx_ready_q, rx_ready_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [63:0] addr_ext_q, addr_ext_d;
  logic        wen_ext_q, wen_ext_d;
  logic [31:0] wdata_ext_q, wdata_ext_d;
  logic [63:0] addr_ext_2_q, addr_ext_2_d;
  logic        wen_ext_2_q, wen_ext_2_d;
  logic        ren_ext_2_q, ren_ext_2_d;
  logic [63:0] wdata_ext_2_q, wdata_ext_2_d;
  logic        cpu_enable_q, cpu_enable_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic        rx_fire, tx_fire, too_big, last_byte;
  logic [31:0] len_full;
  logic [63:0] word_full;
  logic [15:0] idx_inc;

  // Next-state and next-output computation; every output is a flop loaded from here.
  always_comb begin
    rx_fire   = rx_valid && rx_ready_q;
    tx_fire   = tx_valid_q && tx_ready;
    len_full  = len_q | ({24'd0, rx_data} << {cnt_q, 3'b000});
    word_full = word_q | ({56'd0, rx_data} << {cnt_q, 3'b000});
    idx_inc   = idx_q + 16'd1;
    too_big   = (cmd_q == CMD_IMEM) ? ({1'b0, len_full[15:0]} > IMEM_MAX)
                                    : ({1'b0, len_full[15:0]} > DMEM_MAX);
    last_byte = (cmd_q == CMD_IMEM) ? (cnt_q == 3'd3) : (cnt_q == 3'd7);

    state_d       = state_q;
    cmd_d         = cmd_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    idx_d         = idx_q;
    word_d        = word_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    addr_ext_d    = 64'd0;
    wen_ext_d     = 1'b0;
    wdata_ext_d   = 32'd0;
    addr_ext_2_d  = 64'd0;
    wen_ext_2_d   = 1'b0;
    ren_ext_2_d   = 1'b0;
    wdata_ext_2_d = 64'd0;
    cpu_enable_d  = 1'b0;
    err_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_fire) begin
          cnt_d = 3'd0;
          len_d = 32'd0;
          case (rx_data)
            8'h01:   begin cmd_d = CMD_IMEM; state_d = CMD_LEN; end
            8'h02:   begin cmd_d = CMD_DMEM; state_d = CMD_LEN; end
            8'h03:   state_d = RUN_LEN;
            8'h04:   begin cmd_d = CMD_DUMP; state_d = CMD_LEN; end
            default: err_d = 1'b1;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      CMD_LEN: begin
        if (rx_fire) begin
          len_d = len_full;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd1) begin
            cnt_d  = 3'd0;
            idx_d  = 16'd0;
            word_d = 64'd0;
            if (len_full[15:0] == 16'd0) begin
              state_d = IDLE;
            end else if (too_big) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else if (cmd_q == CMD_DUMP) begin
              ren_ext_2_d = 1'b1;
              state_d     = DUMP_RD;
            end else begin
              state_d = LOAD_BYTES;
            end
          end else begin
            state_d = CMD_LEN;
          end
        end else begin
          state_d = CMD_LEN;
        end
      end
      RUN_LEN: begin
        if (rx_fire) begin
          len_d = len_full;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd3) begin
            cnt_d = 3'd0;
            if (len_full == 32'd0) begin
              state_d = IDLE;
            end else begin
              cpu_enable_d = 1'b1;
              state_d      = RUN;
            end
          end else begin
            state_d = RUN_LEN;
          end
        end else begin
          state_d = RUN_LEN;
        end
      end
      LOAD_BYTES: begin
        if (rx_fire) begin
          word_d = word_full;
          cnt_d  = cnt_q + 3'd1;
          if (last_byte) begin
            cnt_d   = 3'd0;
            word_d  = 64'd0;
            state_d = LOAD_WR;
            if (cmd_q == CMD_IMEM) begin
              wen_ext_d   = 1'b1;
              addr_ext_d  = {46'd0, idx_q, 2'b00};
              wdata_ext_d = word_full[31:0];
            end else begin
              wen_ext_2_d   = 1'b1;
              addr_ext_2_d  = {45'd0, idx_q, 3'b000};
              wdata_ext_2_d = word_full;
            end
          end else begin
            state_d = LOAD_BYTES;
          end
        end else begin
          state_d = LOAD_BYTES;
        end
      end
      LOAD_WR: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == len_q[15:0]) ? IDLE : LOAD_BYTES;
      end
      RUN: begin
        // len_q counts the enable cycles still owed, including the current one.
        len_d = len_q - 32'd1;
        if (len_q == 32'd1) begin
          state_d = IDLE;
        end else begin
          cpu_enable_d = 1'b1;
        end
      end
      DUMP_RD: state_d = DUMP_WAIT;
      DUMP_WAIT: begin
        word_d     = rdata_ext_2;
        cnt_d      = 3'd0;
        tx_valid_d = 1'b1;
        tx_data_d  = rdata_ext_2[7:0];
        state_d    = DUMP_TX;
      end
      DUMP_TX: begin
        if (tx_fire) begin
          if (cnt_q == 3'd7) begin
            tx_valid_d = 1'b0;
            cnt_d      = 3'd0;
            idx_d      = idx_inc;
            if (idx_inc == len_q[15:0]) begin
              state_d = IDLE;
            end else begin
              ren_ext_2_d  = 1'b1;
              addr_ext_2_d = {45'd0, idx_inc, 3'b000};
              state_d      = DUMP_RD;
            end
          end else begin
            cnt_d     = cnt_q + 3'd1;
            tx_data_d = word_q[{cnt_q + 3'd1, 3'b000} +: 8];
          end
        end else begin
          state_d = DUMP_TX;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      IDLE, CMD_LEN, RUN_LEN, LOAD_BYTES: rx_ready_d = 1'b1;
      default:                            rx_ready_d = 1'b0;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_q         <= 2'd0;
      cnt_q         <= 3'd0;
      len_q         <= 32'd0;
      idx_q         <= 16'd0;
      word_q        <= 64'd0;
      rx_ready_q    <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= 8'd0;
      addr_ext_q    <= 64'd0;
      wen_ext_q     <= 1'b0;
      wdata_ext_q   <= 32'd0;
      addr_ext_2_q  <= 64'd0;
      wen_ext_2_q   <= 1'b0;
      ren_ext_2_q   <= 1'b0;
      wdata_ext_2_q <= 64'd0;
      cpu_enable_q  <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      word_q        <= word_d;
      rx_ready_q    <= rx_ready_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      addr_ext_q    <= addr_ext_d;
      wen_ext_q     <= wen_ext_d;
      wdata_ext_q   <= wdata_ext_d;
      addr_ext_2_q  <= addr_ext_2_d;
      wen_ext_2_q   <= wen_ext_2_d;
      ren_ext_2_q   <= ren_ext_2_d;
      wdata_ext_2_q <= wdata_ext_2_d;
      cpu_enable_q  <= cpu_enable_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign rx_ready    = rx_ready_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign addr_ext    = addr_ext_q;
  assign wen_ext     = wen_ext_q;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = wdata_ext_q;
  assign addr_ext_2  = addr_ext_2_q;
  assign wen_ext_2   = wen_ext_2_q;
  assign ren_ext_2   = ren_ext_2_q;
  assign wdata_ext_2 = wdata_ext_2_q;
  assign cpu_enable  = cpu_enable_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: doc/cpu_loader.md
CPU_LOADER -- requirements
Module: cpu_loader

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 128, giving the maximum instruction words accepted per load.
REQ-002 SHALL have parameter DMEM_WORDS, default 128, giving the maximum data words accepted per load or dump.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic SHALL be rising-edge clocked.
REQ-004 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-005 SHALL have port rx_valid, input, 1, command/data byte available.
REQ-006 SHALL have port rx_ready, output, 1, byte accepted when rx_valid && rx_ready.
REQ-007 SHALL have port rx_data, input, 8, command/data byte.
REQ-008 SHALL have port tx_valid, output, 1, dump byte available.
REQ-009 SHALL have port tx_ready, input, 1, byte consumed when tx_valid && tx_ready.
REQ-010 SHALL have port tx_data, output, 8, dump byte.
REQ-011 SHALL have ports addr_ext output 64, wen_ext output 1, ren_ext output 1, wdata_ext output 32, driving the CPU instruction-memory external port.
REQ-012 SHALL have ports addr_ext_2 output 64, wen_ext_2 output 1, ren_ext_2 output 1, wdata_ext_2 output 64, rdata_ext_2 input 64, for the CPU data-memory external port.
REQ-013 SHALL have port cpu_enable, output, 1, driving the CPU enable input.
REQ-014 SHALL have ports busy output 1 (state != IDLE) and err output 1 (one-cycle error pulse).

Function
REQ-015 SHALL implement the states IDLE, CMD_LEN, LOAD_BYTES, LOAD_WR, RUN_LEN, RUN, DUMP_RD, DUMP_WAIT, DUMP_TX.
REQ-016 In IDLE, the first accepted byte SHALL be decoded as a command: 0x01 load IMEM, 0x02 load DMEM, 0x03 run, 0x04 dump DMEM.
REQ-017 Any other command byte SHALL pulse err for 1 cycle and leave the block in IDLE.
REQ-018 Commands 0x01, 0x02 and 0x04 SHALL be followed by a 2-byte little-endian word count N; command 0x03 SHALL be followed by a 4-byte little-endian cycle count C.
REQ-019 N greater than the relevant IMEM_WORDS/DMEM_WORDS SHALL pulse err after the count completes and return to IDLE with no memory access.
REQ-020 N=0 or C=0 SHALL return to IDLE with no memory access and no cpu_enable.
REQ-021 Load IMEM: each word SHALL be assembled from 4 bytes, little-endian (first byte = bits 7:0).
REQ-022 Load DMEM: each word SHALL be assembled from 8 bytes, little-endian.
REQ-023 After the last byte of a word, LOAD_WR SHALL assert the relevant wen for exactly 1 cycle, with the word address and data stable in that cycle.
REQ-024 Word k SHALL be written at byte address 4k for IMEM and 8k for DMEM.
REQ-025 rx_ready SHALL be 0 in LOAD_WR, RUN and all DUMP states, and 1 in IDLE, CMD_LEN, RUN_LEN and LOAD_BYTES.
REQ-026 After the Nth write the block SHALL return to IDLE in the next cycle.
REQ-027 Dump: for k=0..N-1, ren_ext_2 SHALL be held 1 for 1 cycle (DUMP_RD) with addr_ext_2=8k; rdata_ext_2 is valid the following cycle (DUMP_WAIT) and SHALL be captured there.
REQ-028 In DUMP_TX the captured word SHALL be sent as 8 bytes, LSB first.
REQ-029 In DUMP_TX, tx_valid SHALL stay high and tx_data stable until tx_ready; the next byte SHALL follow in the cycle after the handshake.
REQ-030 After the last byte of word N-1 the block SHALL return to IDLE.
REQ-031 RUN: cpu_enable SHALL be 1 for exactly C consecutive cycles, starting the cycle after the last count byte, then 0, and the block SHALL return to IDLE.
REQ-032 cpu_enable SHALL be 0 in every state except RUN.
REQ-033 All wen/ren outputs SHALL be 0 in RUN.
REQ-034 Unused ext address and data outputs SHALL be driven 0 when idle.
REQ-035 Counters SHALL be wide enough to hold 16-bit N and 32-bit C without wrap-around.
REQ-036 rx bytes arriving while rx_ready=0 SHALL NOT be consumed.

Reset
REQ-037 While rst=1 at a clock edge: state IDLE; all counters and assembly registers cleared; rx_ready 0 in the reset cycle, 1 from the first cycle after reset; tx_valid, all wen/ren, cpu_enable, err, busy 0; addr/wdata outputs 0.
REQ-038 Reset mid-operation SHALL abort immediately, with no further write, read or enable pulse; partially assembled words SHALL be discarded.

Verification
REQ-039 Bytes 01 02 00 13 00 00 00 93 00 10 00 -> wen_ext at addr 0 with data 0x00000013, then at addr 4 with data 0x00100093; each pulse 1 cycle; then IDLE.
REQ-040 Bytes 02 01 00 then 88 77 66 55 44 33 22 11 -> single wen_ext_2 at addr 0 with data 0x1122334455667788.
REQ-041 Bytes 03 05 00 00 00 -> cpu_enable high for exactly 5 cycles; no wen/ren during RUN.
REQ-042 Bytes 04 01 00 with rdata_ext_2=0x1122334455667788 and tx_ready toggling -> ren_ext_2 at addr 0; tx bytes 88 77 66 55 44 33 22 11 in order, none lost or duplicated.
REQ-043 Command 0x7F -> err 1-cycle pulse, IDLE; bytes 01 FF FF -> err pulse, no wen_ext.
REQ-044 rst asserted after 3 data bytes of an IMEM load -> no wen_ext; all outputs at reset values; a following 01 01 00 + 4 bytes load completes correctly.
